// File: rtl/cpu_ctrl_param.sv
// cpu_ctrl_param: multi-cycle controller for the lab datapath (register file,
// shared bus mux, ALU with operand latch A and result latch G). One instruction
// is accepted per run request; the controller sequences the bus mux, register
// write enables and ALU controls, then pulses done (and illegal for the
// reserved class).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   run      in   start request, sampled only in IDLE
//   d_inst   in   instruction word, sampled in FETCH
//   mux_sel  out  bus source: Rn / NUM_REGS = ext din / NUM_REGS+1 = G
//   en       out  one-hot register write enable
//   en_inst  out  external IR load strobe
//   en_s     out  ALU operand latch A enable
//   en_c     out  ALU result latch G enable
//   sel      out  ALU operation select
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   illegal  out  one-cycle pulse with done for the reserved class
module cpu_ctrl_param #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned INST_W    = 16,
  parameter int unsigned ALU_SEL_W = 3,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS),
  localparam int unsigned MUX_W    = $clog2(NUM_REGS + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [INST_W-1:0]    d_inst,
  output logic [MUX_W-1:0]     mux_sel,
  output logic [NUM_REGS-1:0]  en,
  output logic                 en_inst,
  output logic                 en_s,
  output logic                 en_c,
  output logic [ALU_SEL_W-1:0] sel,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MOV_X,
    S_LDI_X,
    S_ALU_A,
    S_ALU_C,
    S_ALU_W,
    S_DONE
  } state_t;

  localparam logic [1:0] CLS_MOV = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_ALU = 2'b10;
  localparam logic [1:0] CLS_RSV = 2'b11;

  state_t                state, state_d;
  logic [INST_W-1:0]     ir, ir_d;

  logic [IDX_W-1:0]      rd_d, rs_d;
  logic [ALU_SEL_W-1:0]  aop_d;
  logic [1:0]            cls_d;

  logic [MUX_W-1:0]      mux_sel_d;
  logic [NUM_REGS-1:0]   en_d;
  logic                  en_inst_d, en_s_d, en_c_d;
  logic [ALU_SEL_W-1:0]  sel_d;
  logic                  busy_d, done_d, illegal_d;

  // IR loads from d_inst only while in FETCH; later states see the held copy.
  assign ir_d  = (state == S_FETCH) ? d_inst : ir;
  assign rd_d  = ir_d[INST_W-1 -: IDX_W];
  assign rs_d  = ir_d[INST_W-1-IDX_W -: IDX_W];
  assign aop_d = ir_d[ALU_SEL_W+1:2];
  assign cls_d = ir_d[1:0];

  // State, IR and outputs. Outputs are registered from the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      mux_sel <= '0;
      en      <= '0;
      en_inst <= 1'b0;
      en_s    <= 1'b0;
      en_c    <= 1'b0;
      sel     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_d;
      ir      <= ir_d;
      mux_sel <= mux_sel_d;
      en      <= en_d;
      en_inst <= en_inst_d;
      en_s    <= en_s_d;
      en_c    <= en_c_d;
      sel     <= sel_d;
      busy    <= busy_d;
      done    <= done_d;
      illegal <= illegal_d;
    end
  end

  // Next-state transition and Moore decode of the next state's outputs.
  always_comb begin
    state_d   = state;
    mux_sel_d = '0;
    en_d      = '0;
    en_inst_d = 1'b0;
    en_s_d    = 1'b0;
    en_c_d    = 1'b0;
    sel_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        case (cls_d)
          CLS_MOV: state_d = S_MOV_X;
          CLS_LDI: state_d = S_LDI_X;
          CLS_ALU: state_d = S_ALU_A;
          default: state_d = S_DONE;
        endcase
      end
      S_MOV_X: state_d = S_DONE;
      S_LDI_X: state_d = S_DONE;
      S_ALU_A: state_d = S_ALU_C;
      S_ALU_C: state_d = S_ALU_W;
      S_ALU_W: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_FETCH: en_inst_d = 1'b1;
      S_MOV_X: begin
        mux_sel_d  = MUX_W'(rs_d);
        en_d[rd_d] = 1'b1;
      end
      S_LDI_X: begin
        mux_sel_d  = MUX_W'(NUM_REGS);
        en_d[rd_d] = 1'b1;
      end
      S_ALU_A: begin
        mux_sel_d = MUX_W'(rd_d);
        en_s_d    = 1'b1;
      end
      S_ALU_C: begin
        mux_sel_d = MUX_W'(rs_d);
        en_c_d    = 1'b1;
        sel_d     = aop_d;
      end
      S_ALU_W: begin
        mux_sel_d  = MUX_W'(NUM_REGS + 1);
        en_d[rd_d] = 1'b1;
      end
      S_DONE: begin
        done_d    = 1'b1;
        illegal_d = (cls_d == CLS_RSV);
      end
      default: ;
    endcase
  end

endmodule
